// File: rtl/cmos_capture.sv
// CMOS sensor front end: registers the 8-bit parallel bus, pairs bytes into RGB565
// pixels and emits a framed sop/eop/vld stream after discarding settling frames.
module cmos_capture #(
  parameter int unsigned H_PIXEL    = 640,
  parameter int unsigned V_LINE     = 480,
  parameter int unsigned FRAME_SKIP = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_vld,
  output logic [15:0] dout,
  output logic        frame_err
);

  localparam int unsigned ColW  = $clog2(H_PIXEL + 1);
  localparam int unsigned RowW  = $clog2(V_LINE + 1);
  localparam int unsigned SkipW = (FRAME_SKIP == 0) ? 1 : $clog2(FRAME_SKIP + 1);

  localparam logic [1:0] S_SKIP = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;

  logic             vsync_q, href_q, vsync_qq, href_qq;
  logic [7:0]       data_q;
  logic [1:0]       state_q, state_d;
  logic [SkipW-1:0] skip_q, skip_d;
  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic             eop_seen_q, eop_seen_d;
  logic             vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic [15:0]      dout_q, dout_d;
  logic             vs_rise, href_fall, in_range;

  assign vs_rise   = vsync_q & ~vsync_qq;
  assign href_fall = ~href_q & href_qq;
  assign in_range  = (col_q < ColW'(H_PIXEL)) && (row_q < RowW'(V_LINE));

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    phase_d    = 1'b0;
    hi_d       = hi_q;
    col_d      = col_q;
    row_d      = row_q;
    eop_seen_d = eop_seen_q;
    vld_d      = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    dout_d     = dout_q;
    case (state_q)
      S_SKIP: begin
        if (FRAME_SKIP == 0) begin
          state_d = S_WAIT;
        end else if (vs_rise) begin
          if (skip_q == SkipW'(FRAME_SKIP - 1)) state_d = S_WAIT;
          else skip_d = skip_q + SkipW'(1);
        end
      end
      S_WAIT: begin
        if (vs_rise) begin
          state_d    = S_ACT;
          col_d      = '0;
          row_d      = '0;
          eop_seen_d = 1'b0;
        end
      end
      S_ACT: begin
        // Frame start wins over a coincident byte, which is dropped.
        if (vs_rise) begin
          err_d      = ~eop_seen_q;
          col_d      = '0;
          row_d      = '0;
          eop_seen_d = 1'b0;
        end else if (href_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = data_q;
          end else begin
            if (in_range) begin
              vld_d  = 1'b1;
              dout_d = {hi_q, data_q};
              sop_d  = (col_q == '0) && (row_q == '0);
              eop_d  = (col_q == ColW'(H_PIXEL - 1)) && (row_q == RowW'(V_LINE - 1));
              if (eop_d) eop_seen_d = 1'b1;
            end
            if (col_q != ColW'(H_PIXEL)) col_d = col_q + ColW'(1);
          end
        end else if (href_fall) begin
          col_d = '0;
          // Only lines that produced a pixel advance the row; saturate past the frame.
          if ((col_q != '0) && (row_q != RowW'(V_LINE))) row_d = row_q + RowW'(1);
        end
      end
      default: state_d = S_SKIP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      data_q     <= '0;
      vsync_qq   <= 1'b0;
      href_qq    <= 1'b0;
      state_q    <= S_SKIP;
      skip_q     <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      eop_seen_q <= 1'b0;
      vld_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      vsync_q    <= cmos_vsync;
      href_q     <= cmos_href;
      data_q     <= cmos_data;
      vsync_qq   <= vsync_q;
      href_qq    <= href_q;
      state_q    <= state_d;
      skip_q     <= skip_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      col_q      <= col_d;
      row_q      <= row_d;
      eop_seen_q <= eop_seen_d;
      vld_q      <= vld_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
    end
  end

  assign dout_vld  = vld_q;
  assign dout_sop  = sop_q;
  assign dout_eop  = eop_q;
  assign frame_err = err_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Bench for cmos_capture: scoreboarded pixel stream on two instances (skip 2 and skip 0)
// plus directed timing checks for packing latency, short frames, reset and vsync collision.
module tb_cmos_capture;

  localparam int HP = 4;
  localparam int VL = 2;

  typedef struct packed {
    logic [15:0] pix;
    logic        sop;
    logic        eop;
  } exp_t;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, rst0_n;
  logic        cmos_vsync, cmos_href;
  logic [7:0]  cmos_data;
  logic        dout_sop, dout_eop, dout_vld, frame_err;
  logic [15:0] dout;
  logic        dout_sop0, dout_eop0, dout_vld0, frame_err0;
  logic [15:0] dout0;

  exp_t q2[$];
  exp_t q0[$];
  exp_t m2, m0;
  int   n_chk = 0, n_err = 0;
  int   vld2 = 0, sop2 = 0, eop2 = 0, err2 = 0;
  int   vld0 = 0, sop0 = 0, eop0 = 0, err0 = 0;

  always #5 clk = ~clk;

  cmos_capture #(.H_PIXEL(HP), .V_LINE(VL), .FRAME_SKIP(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_vld(dout_vld),
    .dout(dout), .frame_err(frame_err)
  );

  cmos_capture #(.H_PIXEL(HP), .V_LINE(VL), .FRAME_SKIP(0)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .dout_sop(dout_sop0), .dout_eop(dout_eop0), .dout_vld(dout_vld0),
    .dout(dout0), .frame_err(frame_err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dout_vld) begin
      vld2++;
      if (dout_sop) sop2++;
      if (dout_eop) eop2++;
      if (q2.size() == 0) chk("dut2_unexpected_vld", {31'd0, dout_vld}, 32'd0);
      else begin
        m2 = q2.pop_front();
        chk("dut2_dout", {16'd0, dout}, {16'd0, m2.pix});
        chk("dut2_sop", {31'd0, dout_sop}, {31'd0, m2.sop});
        chk("dut2_eop", {31'd0, dout_eop}, {31'd0, m2.eop});
      end
    end
    if (frame_err) err2++;
    if (dout_vld0) begin
      vld0++;
      if (dout_sop0) sop0++;
      if (dout_eop0) eop0++;
      if (q0.size() == 0) chk("dut0_unexpected_vld", {31'd0, dout_vld0}, 32'd0);
      else begin
        m0 = q0.pop_front();
        chk("dut0_dout", {16'd0, dout0}, {16'd0, m0.pix});
        chk("dut0_sop", {31'd0, dout_sop0}, {31'd0, m0.sop});
        chk("dut0_eop", {31'd0, dout_eop0}, {31'd0, m0.eop});
      end
    end
    if (frame_err0) err0++;
  end

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
    cmos_vsync = vs;
    cmos_href  = hr;
    cmos_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic line(input int nbytes, input int row, input bit e2, input bit e0);
    logic [7:0] hi, d;
    int         col;
    exp_t       e;
    hi = 8'h00;
    for (int b = 0; b < nbytes; b++) begin
      d = 8'($urandom_range(0, 255));
      if (b % 2 == 0) hi = d;
      else begin
        col = b / 2;
        if (col < HP && row < VL) begin
          e.pix = {hi, d};
          e.sop = (row == 0 && col == 0);
          e.eop = (row == VL - 1 && col == HP - 1);
          if (e2) q2.push_back(e);
          if (e0) q0.push_back(e);
        end
      end
      cyc(1'b0, 1'b1, d);
    end
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame(input int nl, input bit e2, input bit e0);
    vs_pulse();
    for (int r = 0; r < nl; r++) line(8, r, e2, e0);
  endtask

  initial begin
    vec_t tbl[4];
    exp_t e;
    int   v, s, p, r;
    tbl[0] = '{hi: 8'hF8, lo: 8'h1F, exp: 16'hF81F};
    tbl[1] = '{hi: 8'h07, lo: 8'hE0, exp: 16'h07E0};
    tbl[2] = '{hi: 8'hA5, lo: 8'h5A, exp: 16'hA55A};
    tbl[3] = '{hi: 8'h00, lo: 8'hFF, exp: 16'h00FF};

    rst_n = 1'b0;
    rst0_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk("rst_vld", {31'd0, dout_vld}, 32'd0);
    chk("rst_sop", {31'd0, dout_sop}, 32'd0);
    chk("rst_eop", {31'd0, dout_eop}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst0_dout", {16'd0, dout0}, 32'd0);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 8'h00);

    // Skip two frames, capture the third
    frame(2, 1'b0, 1'b0);
    frame(2, 1'b0, 1'b0);
    chk("skip_no_vld", vld2, 0);
    frame(2, 1'b1, 1'b0);
    chk("cap_vld_cnt", vld2, 8);
    chk("cap_sop_cnt", sop2, 1);
    chk("cap_eop_cnt", eop2, 1);
    chk("cap_no_err", err2, 0);

    // Byte packing and 2-clock pin-to-output latency
    vs_pulse();
    for (int i = 0; i < HP; i++) begin
      e.pix = tbl[i].exp;
      e.sop = (i == 0);
      e.eop = 1'b0;
      q2.push_back(e);
      cyc(1'b0, 1'b1, tbl[i].hi);
      if (i > 0) begin
        chk("pack_vld", {31'd0, dout_vld}, 32'd1);
        chk("pack_dout", {16'd0, dout}, {16'd0, tbl[i-1].exp});
      end
      cyc(1'b0, 1'b1, tbl[i].lo);
      chk("pack_early_vld", {31'd0, dout_vld}, 32'd0);
    end
    cyc(1'b0, 1'b0, 8'h00);
    chk("pack_vld", {31'd0, dout_vld}, 32'd1);
    chk("pack_dout", {16'd0, dout}, {16'd0, tbl[HP-1].exp});
    cyc(1'b0, 1'b0, 8'h00);
    chk("pack_hold_dout", {16'd0, dout}, {16'd0, tbl[HP-1].exp});
    cyc(1'b0, 1'b0, 8'h00);
    line(8, 1, 1'b1, 1'b0);
    chk("pack_no_err", err2, 0);

    // Short frame: one line, then vsync
    v = vld2; p = eop2; r = err2;
    vs_pulse();
    line(8, 0, 1'b1, 1'b0);
    chk("short_vld_cnt", vld2 - v, 4);
    chk("short_no_eop", eop2 - p, 0);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("short_err_pulse", {31'd0, frame_err}, 32'd1);
    cyc(1'b1, 1'b0, 8'h00);
    chk("short_err_width", {31'd0, frame_err}, 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    line(8, 0, 1'b1, 1'b0);
    line(8, 1, 1'b1, 1'b0);
    chk("short_err_cnt", err2 - r, 1);
    chk("short_next_eop", eop2 - p, 1);

    // Overlong line with odd trailing byte, plus an extra third line
    v = vld2; r = err2;
    vs_pulse();
    line(11, 0, 1'b1, 1'b0);
    line(8, 1, 1'b1, 1'b0);
    line(8, 2, 1'b1, 1'b0);
    chk("long_vld_cnt", vld2 - v, 8);
    chk("long_no_err", err2 - r, 0);

    // Reset during the third pixel of an active frame
    r = err2;
    vs_pulse();
    e.sop = 1'b1; e.eop = 1'b0; e.pix = 16'h1234; q2.push_back(e);
    e.sop = 1'b0; e.pix = 16'h5678; q2.push_back(e);
    cyc(1'b0, 1'b1, 8'h12);
    cyc(1'b0, 1'b1, 8'h34);
    cyc(1'b0, 1'b1, 8'h56);
    cyc(1'b0, 1'b1, 8'h78);
    cyc(1'b0, 1'b1, 8'h9A);
    chk("prerst_dout", {16'd0, dout}, 32'h5678);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 8'hBC);
    rst_n = 1'b1;
    chk("midrst_vld", {31'd0, dout_vld}, 32'd0);
    chk("midrst_sop", {31'd0, dout_sop}, 32'd0);
    chk("midrst_eop", {31'd0, dout_eop}, 32'd0);
    chk("midrst_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_dout", {16'd0, dout}, 32'd0);
    cyc(1'b0, 1'b1, 8'hDE);
    cyc(1'b0, 1'b1, 8'hF0);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    v = vld2;
    frame(2, 1'b0, 1'b0);
    frame(2, 1'b0, 1'b0);
    chk("rst_skip_no_vld", vld2 - v, 0);
    frame(2, 1'b1, 1'b0);
    chk("rst_cap_vld_cnt", vld2 - v, 8);
    chk("rst_no_err", err2 - r, 0);

    // FRAME_SKIP=0 instance, and vsync rising on a pixel-completing byte
    rst0_n = 1'b1;
    r = err2; s = sop2;
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    vs_pulse();
    line(8, 0, 1'b1, 1'b1);
    chk("skip0_first_vld", vld0, 4);
    cyc(1'b0, 1'b1, 8'h55);
    cyc(1'b1, 1'b1, 8'hAA);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("coll_err2", err2 - r, 1);
    chk("coll_err0", err0, 1);
    line(8, 0, 1'b1, 1'b1);
    line(8, 1, 1'b1, 1'b1);
    chk("coll_sop2", sop2 - s, 2);
    chk("coll_sop0", sop0, 2);
    chk("coll_eop0", eop0, 1);
    chk("coll_vld0", vld0, 12);

    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    chk("q2_empty", q2.size(), 0);
    chk("q0_empty", q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmos_capture.md
# cmos_capture

Front end of the video pipeline, upstream of the image-processing chain. It samples the CMOS sensor's 8-bit parallel bus (vsync, href, data) in the pixel-clock domain and pairs bytes into RGB565 pixels. It emits them as a framed stream (`dout_sop`/`dout_eop`/`dout_vld`/`dout`), the same protocol the processing chain consumes. After reset it discards a configurable number of frames while the sensor settles. It flags frames that end before the full resolution arrives.

## Interface

**Parameters**
- `H_PIXEL`, default 640: active pixels per line.
- `V_LINE`, default 480: active lines per frame.
- `FRAME_SKIP`, default 10: frames discarded after reset. 0 means no skip.

**Ports**
- `clk`, input, 1: sensor pixel clock; the single clock of the block.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `cmos_vsync`, input, 1: frame sync. Active high; its rising edge marks a frame start.
- `cmos_href`, input, 1: line valid. Each high cycle carries one byte.
- `cmos_data`, input, 8: sensor byte.
- `dout_sop`, output, 1: first pixel of frame (row 0, col 0).
- `dout_eop`, output, 1: last pixel of frame (row `V_LINE`-1, col `H_PIXEL`-1).
- `dout_vld`, output, 1: pixel valid.
- `dout`, output, 16: RGB565 pixel.
- `frame_err`, output, 1: one-cycle pulse when a frame ends short.

## Operation

**Input stage**
- `cmos_vsync`, `cmos_href` and `cmos_data` are registered once (r-stage).
- All logic below works on the r-stage values.
- Edges are detected by comparing the r-stage against a second delayed copy.

**FSM**
- States are S_SKIP, S_WAIT and S_ACT. Reset state is S_SKIP with the skip counter at 0.
- **S_SKIP:** count vsync rising edges. When the count reaches `FRAME_SKIP`, go to S_WAIT. With `FRAME_SKIP`=0, S_SKIP exits to S_WAIT on the first clock after reset.
- **S_WAIT:** on a vsync rising edge, clear the counters and go to S_ACT. That frame is the first one output.
- **S_ACT:** on each vsync rising edge:
  - If the previous frame did not emit eop, pulse `frame_err`.
  - Clear the counters. Stay in S_ACT.

**Byte pairing (S_ACT only)**
- A byte-phase bit toggles on every r-stage href-high cycle and is forced to 0 while href is low.
- Phase 0 latches the high byte, {R[4:0], G[5:3]}.
- Phase 1 completes the pixel, {hi, lo}.
- An odd trailing byte at line end is discarded.

**Counters**
- `col` is 0..`H_PIXEL`-1. It increments per completed pixel and clears on the href falling edge.
- `row` is 0..`V_LINE`-1. It increments on the href falling edge, only if the line produced at least one pixel.
- Pixels with `col` ≥ `H_PIXEL` or `row` ≥ `V_LINE` are dropped: no `dout_vld`, and the counters saturate rather than wrap.
- A short line (fewer than `H_PIXEL` pixels) still advances `row`.

**Output flags** (all apply only to a completed, in-range pixel)
- `dout_vld` is asserted for each such pixel.
- `dout_sop` is asserted with `row`=0 and `col`=0.
- `dout_eop` is asserted with `row`=`V_LINE`-1 and `col`=`H_PIXEL`-1. It sets an internal eop_seen flag, which is cleared at each frame start.
- `frame_err` fires at a vsync rising edge in S_ACT when eop_seen is 0.

**Other rules**
- If vsync rises in the same r-stage cycle as an href-high byte, frame start takes priority: the byte is discarded and the counters are cleared.
- Reset mid-frame: all outputs go to 0 on the next clock and the FSM returns to S_SKIP, so the skip count restarts.

## Timing

- Reset value of every output is 0, including `dout`.
- Outputs are registered.
- A low byte present on the pins at edge k is sampled into the r-stage at edge k. The pixel appears on the outputs after edge k+1. Latency is therefore 2 clocks from pin to `dout_vld`.
- Flags are single-cycle pulses aligned with `dout_vld`. `dout` holds its value when `dout_vld` is 0.
- There is no backpressure; the downstream block must accept one pixel every 2 clocks.
- Maximum output rate is one pixel per 2 clocks.

## Test plan

Bench uses `H_PIXEL`=4, `V_LINE`=2, `FRAME_SKIP`=2.

1. **Skip then capture.** Drive 3 frames of 2 lines × 8 bytes.
   - Frames 1-2: no `dout_vld`.
   - Frame 3: exactly 8 `dout_vld`, sop on the first, eop on the 8th, `frame_err` never pulses.
2. **Byte packing.** Bytes 0xF8,0x1F → `dout`=0xF81F, 2 clocks after the 0x1F byte on the pins. Bytes 0x07,0xE0 → 0x07E0.
3. **Short frame.** In S_ACT, send 1 line only, then a vsync rise.
   - 4 `dout_vld`, no eop.
   - `frame_err` pulses for exactly 1 cycle after the vsync edge.
   - The next full frame gets sop/eop correctly.
4. **Overlong line / odd byte.**
   - 11 bytes in line 0: only 4 pixels valid, the 11th byte is ignored, line 1 starts at col 0.
   - An extra 3rd line produces no `dout_vld`.
5. **Reset mid-frame.** Assert `rst_n`=0 for 1 clock during pixel 3 of an active frame.
   - All outputs are 0 on the next clock.
   - The following 2 frames are discarded and the 3rd is output.
6. **`FRAME_SKIP`=0 and vsync/href collision.** The first full frame after reset is output. A byte coincident with the vsync rise is discarded and the counters show col=0, row=0.
